// File: rtl/rf_writeback_arbiter_if.sv
// ----------------------------------------------------------------------------
// rf_writeback_arbiter_if
//
// Purpose: bundles the result channels coming from the four execution units
// together with the register-file write ports and the pending-write bitmap
// produced by rf_writeback_arbiter.
//
// Signals (k = channel / write port index 0..3):
//   res_valid [3:0]          channel k carries a result
//   res_ready [3:0]          channel k FIFO can accept a result
//   res_addr  [3:0][AW-1:0]  destination register of channel k
//   res_data  [3:0][WW-1:0]  result data of channel k
//   res_seq   [3:0][SW-1:0]  program-order tag of channel k
//   wr_enable [3:0]          register-file write enable, port k
//   wr_select [3:0][AW-1:0]  register-file write select, port k
//   wr_data   [3:0][WW-1:0]  register-file write data, port k
//   pending   [UNITS-1:0]    bit r set while any write to register r is in flight
//
// Modports:
//   master - the execution-unit / register-file side (drives results)
//   slave  - the arbiter itself
// ----------------------------------------------------------------------------
interface rf_writeback_arbiter_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int SEQ_WIDTH     = 6
);
  localparam int UNITS = 2 ** ADDRESS_WIDTH;

  logic [3:0]                    res_valid;
  logic [3:0]                    res_ready;
  logic [3:0][ADDRESS_WIDTH-1:0] res_addr;
  logic [3:0][WORD_WIDTH-1:0]    res_data;
  logic [3:0][SEQ_WIDTH-1:0]     res_seq;

  logic [3:0]                    wr_enable;
  logic [3:0][ADDRESS_WIDTH-1:0] wr_select;
  logic [3:0][WORD_WIDTH-1:0]    wr_data;

  logic [UNITS-1:0]              pending;

  modport master (
    output res_valid,
    output res_addr,
    output res_data,
    output res_seq,
    input  res_ready,
    input  wr_enable,
    input  wr_select,
    input  wr_data,
    input  pending
  );

  modport slave (
    input  res_valid,
    input  res_addr,
    input  res_data,
    input  res_seq,
    output res_ready,
    output wr_enable,
    output wr_select,
    output wr_data,
    output pending
  );

endinterface

// File: rtl/rf_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// rf_writeback_arbiter
//
// Purpose: collects results from the four execution units (arithmetic, logic,
// shift0, shift1), buffers each channel in a 2-deep FIFO and drives the four
// register-file write ports. When several channel heads target the same
// register, only the oldest one (by program-order tag) is written in that
// cycle, so program order is kept and no register sees two writes in one
// cycle. A pending-write bitmap is exported for hazard checks in issue logic.
//
// Ports:
//   clk_i   in  clock, all state updates on the rising edge
//   rst_i   in  synchronous active-high reset; clears FIFOs and write ports
//   bus     rf_writeback_arbiter_if.slave
//           res_* : valid/ready result channels, one per execution unit
//           wr_*  : registered register-file write ports, one per channel
//           pending : per-register in-flight bitmap (state only)
// ----------------------------------------------------------------------------
module rf_writeback_arbiter #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int SEQ_WIDTH     = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  rf_writeback_arbiter_if.slave bus
);

  localparam int CHANNELS = 4;
  localparam int DEPTH    = 2;
  localparam int UNITS    = 2 ** ADDRESS_WIDTH;

  // Per-channel FIFO storage, one entry = {addr, data, seq}.
  logic [ADDRESS_WIDTH-1:0] fifo_addr [CHANNELS][DEPTH];
  logic [WORD_WIDTH-1:0]    fifo_data [CHANNELS][DEPTH];
  logic [SEQ_WIDTH-1:0]     fifo_seq  [CHANNELS][DEPTH];

  // FIFO bookkeeping: 1-bit pointers that wrap 1 -> 0, count 0..2.
  logic [CHANNELS-1:0] wr_ptr;
  logic [CHANNELS-1:0] rd_ptr;
  logic [1:0]          count [CHANNELS];

  // Handshake and arbitration signals.
  logic [CHANNELS-1:0] ready;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] nonempty;
  logic [CHANNELS-1:0] eligible;

  // Head-of-FIFO fields per channel.
  logic [ADDRESS_WIDTH-1:0] head_addr [CHANNELS];
  logic [WORD_WIDTH-1:0]    head_data [CHANNELS];
  logic [SEQ_WIDTH-1:0]     head_seq  [CHANNELS];

  // Registered write-port outputs.
  logic [CHANNELS-1:0]                    enable_q;
  logic [CHANNELS-1:0][ADDRESS_WIDTH-1:0] select_q;
  logic [CHANNELS-1:0][WORD_WIDTH-1:0]    data_q;

  logic [UNITS-1:0] pending;

  // Age comparison on wrapping tags: a is older than b when (a - b) taken
  // modulo 2**SEQ_WIDTH is negative. Equal tags fall back to the channel
  // index so that exactly one of two colliding heads wins.
  function automatic logic is_older(input logic [SEQ_WIDTH-1:0] seq_a,
                                    input logic [SEQ_WIDTH-1:0] seq_b,
                                    input logic                 lower_index);
    logic [SEQ_WIDTH-1:0] diff;
    diff = seq_a - seq_b;
    return diff[SEQ_WIDTH-1] || ((diff == '0) && lower_index);
  endfunction

  // An entry slot holds a live result when the FIFO is full, or when it holds
  // one result and the read pointer sits on that slot.
  function automatic logic entry_live(input logic [1:0] cnt,
                                      input logic       rd,
                                      input logic       slot);
    return (cnt == 2'd2) || ((cnt == 2'd1) && (rd == slot));
  endfunction

  // Ready depends only on the FIFO count: a full FIFO refuses new results even
  // if its head leaves in the same cycle, so there is no ready-to-pop path.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      ready[k]     = (count[k] < 2'd2);
      nonempty[k]  = (count[k] != 2'd0);
      push[k]      = bus.res_valid[k] && ready[k];
      head_addr[k] = fifo_addr[k][rd_ptr[k]];
      head_data[k] = fifo_data[k][rd_ptr[k]];
      head_seq[k]  = fifo_seq[k][rd_ptr[k]];
    end
  end

  // A head may issue unless some other non-empty head targets the same
  // register and is older; the loser simply waits in its FIFO.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      eligible[k] = nonempty[k];
      for (int j = 0; j < CHANNELS; j++) begin
        if ((j != k) && nonempty[j] && (head_addr[j] == head_addr[k]) &&
            is_older(head_seq[j], head_seq[k], logic'(j < k))) begin
          eligible[k] = 1'b0;
        end
      end
    end
  end

  // FIFO pointers and counts. Every eligible head pops in the same edge it is
  // loaded into the write-port registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        count[k] <= 2'd0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (push[k]) begin
          wr_ptr[k] <= ~wr_ptr[k];
        end
        if (eligible[k]) begin
          rd_ptr[k] <= ~rd_ptr[k];
        end
        case ({push[k], eligible[k]})
          2'b10:   count[k] <= count[k] + 2'd1;
          2'b01:   count[k] <= count[k] - 2'd1;
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  // FIFO payload storage. Contents need no reset because the counts decide
  // which slots are live.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (push[k] && !rst_i) begin
        fifo_addr[k][wr_ptr[k]] <= bus.res_addr[k];
        fifo_data[k][wr_ptr[k]] <= bus.res_data[k];
        fifo_seq[k][wr_ptr[k]]  <= bus.res_seq[k];
      end
    end
  end

  // Write-port registers. Enable follows eligibility every cycle; select and
  // data only change when the port issues.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q <= '0;
      select_q <= '0;
      data_q   <= '0;
    end else begin
      enable_q <= eligible;
      for (int k = 0; k < CHANNELS; k++) begin
        if (eligible[k]) begin
          select_q[k] <= head_addr[k];
          data_q[k]   <= head_data[k];
        end
      end
    end
  end

  // Pending bitmap: any live FIFO entry or any write being presented to the
  // register file marks its destination. Built from state only.
  always_comb begin
    pending = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (entry_live(count[k], rd_ptr[k], e[0])) begin
          pending[fifo_addr[k][e]] = 1'b1;
        end
      end
      if (enable_q[k]) begin
        pending[select_q[k]] = 1'b1;
      end
    end
  end

  assign bus.res_ready = ready;
  assign bus.wr_enable = enable_q;
  assign bus.wr_select = select_q;
  assign bus.wr_data   = data_q;
  assign bus.pending   = pending;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_writeback_arbiter
//
// Purpose: directed self-checking bench for rf_writeback_arbiter. Inputs are
// driven 1 time unit after each rising edge, and outputs are sampled at the
// same point, i.e. they show the state left by the preceding edge.
// ----------------------------------------------------------------------------
module tb_rf_writeback_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rf_writeback_arbiter_if bus ();

  rf_writeback_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one result channel.
  task automatic apply_stimulus(input int          k,
                                input logic        valid,
                                input logic [3:0]  addr,
                                input logic [31:0] data,
                                input logic [5:0]  seq);
    bus.res_valid[k] = valid;
    bus.res_addr[k]  = addr;
    bus.res_data[k]  = data;
    bus.res_seq[k]   = seq;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(k, 1'b0, 4'd0, 32'd0, 6'd0);
    end
  endtask

  task automatic check_output(input string       tag,
                              input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  initial begin
    // Reset for two edges with every channel offering a result.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(k, 1'b1, 4'(k + 8), 32'hDEAD_0000 + 32'(k), 6'(k));
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_all();
    check_output("reset_enable",  64'(bus.wr_enable), 64'h0);
    check_output("reset_select",  64'(bus.wr_select), 64'h0);
    check_output("reset_data0",   64'(bus.wr_data[0]), 64'h0);
    check_output("reset_pending", 64'(bus.pending),   64'h0);
    check_output("reset_ready",   64'(bus.res_ready), 64'hF);
    tick();
    check_output("reset_empty_enable",  64'(bus.wr_enable), 64'h0);
    check_output("reset_empty_pending", 64'(bus.pending),   64'h0);

    // Single write on channel 0.
    apply_stimulus(0, 1'b1, 4'd3, 32'hA5A5_0001, 6'd1);
    tick();
    idle_all();
    check_output("single_pending_e",  64'(bus.pending),   64'h0008);
    check_output("single_enable_e",   64'(bus.wr_enable), 64'h0);
    tick();
    check_output("single_enable",     64'(bus.wr_enable), 64'h1);
    check_output("single_select",     64'(bus.wr_select[0]), 64'd3);
    check_output("single_data",       64'(bus.wr_data[0]), 64'hA5A5_0001);
    check_output("single_pending_e1", 64'(bus.pending),   64'h0008);
    tick();
    check_output("single_enable_off", 64'(bus.wr_enable), 64'h0);
    check_output("single_pending_e2", 64'(bus.pending),   64'h0);
    check_output("single_select_hold", 64'(bus.wr_select[0]), 64'd3);

    // Same-register collision: channel 3 holds the older tag.
    apply_stimulus(1, 1'b1, 4'd5, 32'h1111_0007, 6'd7);
    apply_stimulus(3, 1'b1, 4'd5, 32'h3333_0006, 6'd6);
    tick();
    idle_all();
    check_output("coll_pending", 64'(bus.pending), 64'h0020);
    tick();
    check_output("coll_first_enable", 64'(bus.wr_enable), 64'h8);
    check_output("coll_first_select", 64'(bus.wr_select[3]), 64'd5);
    check_output("coll_first_data",   64'(bus.wr_data[3]), 64'h3333_0006);
    tick();
    check_output("coll_second_enable", 64'(bus.wr_enable), 64'h2);
    check_output("coll_second_data",   64'(bus.wr_data[1]), 64'h1111_0007);
    check_output("coll_second_pending", 64'(bus.pending), 64'h0020);
    tick();
    check_output("coll_done_enable",  64'(bus.wr_enable), 64'h0);
    check_output("coll_done_pending", 64'(bus.pending),   64'h0);

    // Tag wrap: 63 is older than 0.
    apply_stimulus(0, 1'b1, 4'd2, 32'h0000_D000, 6'd63);
    apply_stimulus(2, 1'b1, 4'd2, 32'h0000_D002, 6'd0);
    tick();
    idle_all();
    tick();
    check_output("wrap_first_enable", 64'(bus.wr_enable), 64'h1);
    check_output("wrap_first_data",   64'(bus.wr_data[0]), 64'h0000_D000);
    tick();
    check_output("wrap_second_enable", 64'(bus.wr_enable), 64'h4);
    check_output("wrap_second_data",   64'(bus.wr_data[2]), 64'h0000_D002);
    tick();
    check_output("wrap_done_enable", 64'(bus.wr_enable), 64'h0);

    // Equal tags on the same register: the lower channel goes first.
    apply_stimulus(0, 1'b1, 4'd9, 32'h7777_0000, 6'd4);
    apply_stimulus(2, 1'b1, 4'd9, 32'h7777_0002, 6'd4);
    tick();
    idle_all();
    tick();
    check_output("tie_first_enable",  64'(bus.wr_enable), 64'h1);
    tick();
    check_output("tie_second_enable", 64'(bus.wr_enable), 64'h4);
    check_output("tie_second_data",   64'(bus.wr_data[2]), 64'h7777_0002);
    tick();

    // Four distinct registers (including register 0) issue in parallel.
    apply_stimulus(0, 1'b1, 4'd1, 32'hC0C0_0001, 6'd10);
    apply_stimulus(1, 1'b1, 4'd2, 32'hC1C1_0002, 6'd11);
    apply_stimulus(2, 1'b1, 4'd3, 32'hC2C2_0003, 6'd12);
    apply_stimulus(3, 1'b1, 4'd0, 32'hC3C3_0000, 6'd13);
    tick();
    idle_all();
    check_output("par_pending_e", 64'(bus.pending), 64'h000F);
    tick();
    check_output("par_enable",  64'(bus.wr_enable), 64'hF);
    check_output("par_select",  64'(bus.wr_select), 64'h0321);
    check_output("par_data3",   64'(bus.wr_data[3]), 64'hC3C3_0000);
    check_output("par_pending", 64'(bus.pending),   64'h000F);
    tick();
    check_output("par_done", 64'(bus.wr_enable), 64'h0);

    // Backpressure: channel 0 streams older writes to register 7 for four
    // cycles, stalling channel 1 which offers three results.
    apply_stimulus(0, 1'b1, 4'd7, 32'hC000_0000, 6'd10);
    apply_stimulus(1, 1'b1, 4'd7, 32'hB000_0001, 6'd20);
    tick();
    apply_stimulus(0, 1'b1, 4'd7, 32'hC000_0001, 6'd11);
    apply_stimulus(1, 1'b1, 4'd7, 32'hB000_0002, 6'd21);
    check_output("bp_ready_one", 64'(bus.res_ready), 64'hF);
    tick();
    check_output("bp_ready_full", 64'(bus.res_ready), 64'hD);
    check_output("bp_e1_enable",  64'(bus.wr_enable), 64'h1);
    check_output("bp_e1_data",    64'(bus.wr_data[0]), 64'hC000_0000);
    apply_stimulus(0, 1'b1, 4'd7, 32'hC000_0002, 6'd12);
    apply_stimulus(1, 1'b1, 4'd7, 32'hB000_0003, 6'd22);
    tick();
    check_output("bp_e2_enable", 64'(bus.wr_enable), 64'h1);
    check_output("bp_e2_data",   64'(bus.wr_data[0]), 64'hC000_0001);
    check_output("bp_e2_ready",  64'(bus.res_ready), 64'hD);
    apply_stimulus(0, 1'b1, 4'd7, 32'hC000_0003, 6'd13);
    tick();
    check_output("bp_e3_enable", 64'(bus.wr_enable), 64'h1);
    check_output("bp_e3_data",   64'(bus.wr_data[0]), 64'hC000_0002);
    apply_stimulus(0, 1'b0, 4'd0, 32'd0, 6'd0);
    tick();
    check_output("bp_e4_enable", 64'(bus.wr_enable), 64'h1);
    check_output("bp_e4_data",   64'(bus.wr_data[0]), 64'hC000_0003);
    check_output("bp_e4_ready",  64'(bus.res_ready), 64'hD);
    tick();
    check_output("bp_e5_enable", 64'(bus.wr_enable), 64'h2);
    check_output("bp_e5_data",   64'(bus.wr_data[1]), 64'hB000_0001);
    check_output("bp_e5_ready",  64'(bus.res_ready), 64'hF);
    tick();
    idle_all();
    check_output("bp_e6_enable", 64'(bus.wr_enable), 64'h2);
    check_output("bp_e6_data",   64'(bus.wr_data[1]), 64'hB000_0002);
    tick();
    check_output("bp_e7_enable", 64'(bus.wr_enable), 64'h2);
    check_output("bp_e7_data",   64'(bus.wr_data[1]), 64'hB000_0003);
    tick();
    check_output("bp_e8_enable",  64'(bus.wr_enable), 64'h0);
    check_output("bp_e8_pending", 64'(bus.pending),   64'h0);
    tick();
    check_output("bp_no_dup", 64'(bus.wr_enable), 64'h0);

    // Reset while channel 2 holds two queued results behind older ones.
    apply_stimulus(0, 1'b1, 4'd4, 32'hE000_0000, 6'd28);
    apply_stimulus(1, 1'b1, 4'd4, 32'hE000_0001, 6'd29);
    apply_stimulus(2, 1'b1, 4'd4, 32'hE000_0002, 6'd30);
    tick();
    idle_all();
    apply_stimulus(2, 1'b1, 4'd4, 32'hE000_0003, 6'd31);
    tick();
    check_output("mid_enable_pre",  64'(bus.wr_enable), 64'h1);
    check_output("mid_ready_pre",   64'(bus.res_ready), 64'hB);
    check_output("mid_pending_pre", 64'(bus.pending),   64'h0010);
    idle_all();
    apply_stimulus(3, 1'b1, 4'd6, 32'hE000_0006, 6'd32);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_all();
    check_output("mid_enable",  64'(bus.wr_enable), 64'h0);
    check_output("mid_select",  64'(bus.wr_select), 64'h0);
    check_output("mid_pending", 64'(bus.pending),   64'h0);
    check_output("mid_ready",   64'(bus.res_ready), 64'hF);
    tick();
    check_output("mid_after_enable",  64'(bus.wr_enable), 64'h0);
    check_output("mid_after_pending", 64'(bus.pending),   64'h0);
    tick();
    check_output("mid_after2_enable", 64'(bus.wr_enable), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
